// File: rtl/pipelined_register_file_if.sv
// Bus bundle between decode/write-back (master) and the register file (slave).
interface pipelined_register_file_if #(
   parameter int WORD_SIZE  = 32,
   parameter int ADDR_WIDTH = 5
);
   logic [ADDR_WIDTH-1:0] rs1;
   logic [ADDR_WIDTH-1:0] rs2;
   logic [WORD_SIZE-1:0]  rv1;
   logic [WORD_SIZE-1:0]  rv2;
   logic                  busy1;
   logic                  busy2;
   logic                  issue_en;
   logic [ADDR_WIDTH-1:0] issue_rd;
   logic                  wb_en;
   logic [ADDR_WIDTH-1:0] wb_rd;
   logic [WORD_SIZE-1:0]  wb_data;
   logic                  flush;
   logic [ADDR_WIDTH-1:0] debug_reg;
   logic [WORD_SIZE-1:0]  debug_reg_out;
   logic [ADDR_WIDTH:0]   pending_count;

   modport master (
      output rs1, rs2, issue_en, issue_rd, wb_en, wb_rd, wb_data, flush, debug_reg,
      input  rv1, rv2, busy1, busy2, debug_reg_out, pending_count
   );

   modport slave (
      input  rs1, rs2, issue_en, issue_rd, wb_en, wb_rd, wb_data, flush, debug_reg,
      output rv1, rv2, busy1, busy2, debug_reg_out, pending_count
   );
endinterface

// File: rtl/pipelined_register_file.sv
// Integer register file: two read ports with optional write-back bypass,
// one write-back port, debug read port and a pending-write scoreboard.
module pipelined_register_file #(
   parameter int                   WORD_SIZE  = 32,
   parameter int                   ADDR_WIDTH = 5,
   parameter logic [WORD_SIZE-1:0] SP_RESET   = 'h7ffc,
   parameter logic [WORD_SIZE-1:0] GP_RESET   = 'h1000,
   parameter bit                   BYPASS     = 1'b1
) (
   input logic                  clk,
   input logic                  rst,
   pipelined_register_file_if.slave bus
);
   localparam int NUM_REGS = 2 ** ADDR_WIDTH;
   localparam int CW       = ADDR_WIDTH + 1;

   logic [WORD_SIZE-1:0] regs [NUM_REGS];
   logic [NUM_REGS-1:0]  pending_q;
   logic [NUM_REGS-1:0]  pending_nxt;
   logic [CW-1:0]        count_q;
   logic [CW-1:0]        count_nxt;

   logic wb_live;
   logic issue_live;
   logic wb_clears;
   logic fwd1;
   logic fwd2;
   logic cnt_inc;
   logic cnt_dec;

   assign wb_live    = bus.wb_en && (bus.wb_rd != '0);
   assign issue_live = bus.issue_en && (bus.issue_rd != '0);
   // An issue to the same rd re-arms the hazard, so that write-back must not clear it.
   assign wb_clears  = wb_live && !(issue_live && (bus.issue_rd == bus.wb_rd));

   assign fwd1 = BYPASS && wb_live && (bus.wb_rd == bus.rs1);
   assign fwd2 = BYPASS && wb_live && (bus.wb_rd == bus.rs2);

   // Combinational read ports with same-cycle write-back forwarding.
   always_comb begin
      bus.rv1 = regs[bus.rs1];
      bus.rv2 = regs[bus.rs2];
      if (fwd1) bus.rv1 = bus.wb_data;
      if (fwd2) bus.rv2 = bus.wb_data;
      if (bus.rs1 == '0) bus.rv1 = '0;
      if (bus.rs2 == '0) bus.rv2 = '0;
   end

   // Hazard flags; a forwarded value satisfies the dependency this cycle.
   always_comb begin
      bus.busy1 = pending_q[bus.rs1] && !fwd1 && (bus.rs1 != '0);
      bus.busy2 = pending_q[bus.rs2] && !fwd2 && (bus.rs2 != '0);
   end

   assign bus.debug_reg_out = regs[bus.debug_reg];
   assign bus.pending_count = count_q;

   // Register storage; r0 is never written so it stays zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (i == 2)      regs[i] <= SP_RESET;
            else if (i == 3) regs[i] <= GP_RESET;
            else             regs[i] <= '0;
         end
      end else if (wb_live) begin
         regs[bus.wb_rd] <= bus.wb_data;
      end
   end

   // Next scoreboard state: flush, then issue set, then write-back clear.
   always_comb begin
      pending_nxt = pending_q;
      cnt_inc     = 1'b0;
      cnt_dec     = 1'b0;
      if (bus.flush) begin
         pending_nxt = '0;
      end else begin
         if (wb_clears) begin
            pending_nxt[bus.wb_rd] = 1'b0;
            cnt_dec                = pending_q[bus.wb_rd];
         end
         if (issue_live) begin
            pending_nxt[bus.issue_rd] = 1'b1;
            cnt_inc                   = !pending_q[bus.issue_rd];
         end
      end
   end

   // Incremental population count, kept in step with the pending bits.
   always_comb begin
      if (bus.flush) count_nxt = '0;
      else           count_nxt = count_q + CW'(cnt_inc) - CW'(cnt_dec);
   end

   // Scoreboard and count registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_q <= '0;
         count_q   <= '0;
      end else begin
         pending_q <= pending_nxt;
         count_q   <= count_nxt;
      end
   end
endmodule

// File: tb/tb_pipelined_register_file.sv
// Directed bench: one bypassing and one non-bypassing instance driven in lockstep.
module tb_pipelined_register_file;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   pipelined_register_file_if #(.WORD_SIZE(32), .ADDR_WIDTH(5)) bus_b ();
   pipelined_register_file_if #(.WORD_SIZE(32), .ADDR_WIDTH(5)) bus_n ();

   pipelined_register_file #(.BYPASS(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
   pipelined_register_file #(.BYPASS(1'b0)) dut_n (.clk(clk), .rst(rst), .bus(bus_n));

   // Mirror all stimulus into the non-bypassing instance.
   assign bus_n.rs1       = bus_b.rs1;
   assign bus_n.rs2       = bus_b.rs2;
   assign bus_n.issue_en  = bus_b.issue_en;
   assign bus_n.issue_rd  = bus_b.issue_rd;
   assign bus_n.wb_en     = bus_b.wb_en;
   assign bus_n.wb_rd     = bus_b.wb_rd;
   assign bus_n.wb_data   = bus_b.wb_data;
   assign bus_n.flush     = bus_b.flush;
   assign bus_n.debug_reg = bus_b.debug_reg;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus_b.issue_en = 1'b0;
      bus_b.wb_en    = 1'b0;
      bus_b.flush    = 1'b0;
   endtask

   task automatic wb(input logic [4:0] rd, input logic [31:0] d);
      bus_b.wb_en   = 1'b1;
      bus_b.wb_rd   = rd;
      bus_b.wb_data = d;
   endtask

   task automatic issue(input logic [4:0] rd);
      bus_b.issue_en = 1'b1;
      bus_b.issue_rd = rd;
   endtask

   logic [31:0] exp_r;

   initial begin
      bus_b.rs1 = 5'd9; bus_b.rs2 = 5'd5;
      bus_b.issue_rd = '0; bus_b.wb_rd = '0; bus_b.wb_data = '0;
      bus_b.debug_reg = '0;
      idle();
      #12 rst = 1'b1;

      // Reset contents through the debug port
      for (int i = 0; i < 32; i++) begin
         bus_b.debug_reg = 5'(i);
         #1;
         exp_r = (i == 2) ? 32'h7ffc : (i == 3) ? 32'h1000 : 32'h0;
         chk($sformatf("reset_r%0d", i), bus_b.debug_reg_out, exp_r);
      end
      chk("reset_count", 32'(bus_b.pending_count), 32'd0);
      chk("reset_busy1", 32'(bus_b.busy1), 32'd0);
      chk("reset_busy2", 32'(bus_b.busy2), 32'd0);

      // Write r5, read next cycle
      tick(); wb(5'd5, 32'hdeadbeef);
      tick(); idle(); bus_b.rs1 = 5'd5; #1;
      chk("wr_rv1_b", bus_b.rv1, 32'hdeadbeef);
      chk("wr_rv1_n", bus_n.rv1, 32'hdeadbeef);

      // Write to r0 is discarded, r0 reads 0 even during the write
      wb(5'd0, 32'h1); bus_b.rs2 = 5'd0; #1;
      chk("r0_rv2_during_b", bus_b.rv2, 32'h0);
      tick(); idle(); bus_b.debug_reg = 5'd0; #1;
      chk("r0_rv2_b", bus_b.rv2, 32'h0);
      chk("r0_rv2_n", bus_n.rv2, 32'h0);
      chk("r0_debug", bus_b.debug_reg_out, 32'h0);

      // Bypass: r7 holds 0x11, pending, then written 0x55 while being read
      wb(5'd7, 32'h11);
      tick(); idle(); issue(5'd7);
      tick(); idle(); bus_b.rs1 = 5'd7; bus_b.debug_reg = 5'd7; #1;
      chk("byp_busy_pre_b", 32'(bus_b.busy1), 32'd1);
      chk("byp_count_pre", 32'(bus_b.pending_count), 32'd1);
      wb(5'd7, 32'h55); #1;
      chk("byp_rv1_b", bus_b.rv1, 32'h55);
      chk("byp_busy1_b", 32'(bus_b.busy1), 32'd0);
      chk("byp_debug_b", bus_b.debug_reg_out, 32'h11);
      chk("nobyp_rv1_n", bus_n.rv1, 32'h11);
      chk("nobyp_busy1_n", 32'(bus_n.busy1), 32'd1);
      tick(); idle(); #1;
      chk("byp_after_rv1_n", bus_n.rv1, 32'h55);
      chk("byp_after_busy1_n", 32'(bus_n.busy1), 32'd0);
      chk("byp_after_count", 32'(bus_b.pending_count), 32'd0);

      // Scoreboard: issue r9 twice, then write back
      issue(5'd9); bus_b.rs1 = 5'd9;
      tick(); #1;
      chk("sb_busy1", 32'(bus_b.busy1), 32'd1);
      chk("sb_count1", 32'(bus_b.pending_count), 32'd1);
      tick(); idle(); #1;
      chk("sb_reissue_count", 32'(bus_b.pending_count), 32'd1);
      chk("sb_reissue_busy", 32'(bus_b.busy1), 32'd1);
      wb(5'd9, 32'h10); #1;
      chk("sb_wb_busy_b", 32'(bus_b.busy1), 32'd0);
      tick(); idle(); #1;
      chk("sb_wb_count", 32'(bus_b.pending_count), 32'd0);
      chk("sb_wb_busy1", 32'(bus_b.busy1), 32'd0);
      chk("sb_wb_rv1", bus_b.rv1, 32'h10);

      // Issue and wb to the same pending register in one cycle
      issue(5'd4);
      tick(); idle(); issue(5'd4); wb(5'd4, 32'h44);
      tick(); idle(); bus_b.rs1 = 5'd4; bus_b.debug_reg = 5'd4; #1;
      chk("sim_data", bus_b.debug_reg_out, 32'h44);
      chk("sim_busy", 32'(bus_b.busy1), 32'd1);
      chk("sim_count", 32'(bus_b.pending_count), 32'd1);

      // Issue r1, r2, r6 then flush with wb r1 and a discarded issue r10
      issue(5'd1);
      tick(); issue(5'd2);
      tick(); issue(5'd6);
      tick(); idle(); #1;
      chk("pre_flush_count", 32'(bus_b.pending_count), 32'd4);
      bus_b.flush = 1'b1; wb(5'd1, 32'habc); issue(5'd10);
      tick(); idle(); bus_b.rs1 = 5'd10; bus_b.rs2 = 5'd2; bus_b.debug_reg = 5'd1; #1;
      chk("flush_count", 32'(bus_b.pending_count), 32'd0);
      chk("flush_r1", bus_b.debug_reg_out, 32'habc);
      chk("flush_busy_r10", 32'(bus_b.busy1), 32'd0);
      chk("flush_busy_r2", 32'(bus_b.busy2), 32'd0);

      // Async reset mid-operation
      issue(5'd11);
      tick(); issue(5'd12);
      tick(); issue(5'd13); wb(5'd5, 32'h5555);
      tick(); idle(); bus_b.debug_reg = 5'd5; #1;
      chk("pre_rst_count", 32'(bus_b.pending_count), 32'd3);
      chk("pre_rst_r5", bus_b.debug_reg_out, 32'h5555);
      #1 rst = 1'b0; #1;
      chk("arst_count", 32'(bus_b.pending_count), 32'd0);
      chk("arst_r5", bus_b.debug_reg_out, 32'h0);
      bus_b.debug_reg = 5'd2; #1;
      chk("arst_r2", bus_b.debug_reg_out, 32'h7ffc);
      #1 rst = 1'b1;
      tick(); #1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/pipelined_register_file.md
# pipelined_register_file

Parametrised integer register file for the pipelined core. It provides two read ports, one write-back port and a debug read port. A per-register pending scoreboard lets decode detect RAW hazards against in-flight writes. Optional same-cycle write-to-read bypass lets decode consume a write-back value without a stall. It sits between decode (reads, issue marking) and write-back (register writes, pending clear).

## Interface
- WORD_SIZE, 32, data width in bits
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH (legal 3..5)
- SP_RESET, 32'h7ffc, reset value of register 2
- GP_RESET, 32'h1000, reset value of register 3
- BYPASS, 1, 1 = forward same-cycle write-back data to read ports; 0 = no forwarding

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- rs1, rs2  in  ADDR_WIDTH  read-port indices
- rv1, rv2  out  WORD_SIZE  read data
- busy1, busy2  out  1  source register has an outstanding write not yet satisfied
- issue_en  in  1  mark issue_rd pending (instruction with a destination issued)
- issue_rd  in  ADDR_WIDTH  destination being issued
- wb_en  in  1  write-back strobe
- wb_rd  in  ADDR_WIDTH  write-back destination
- wb_data  in  WORD_SIZE  write-back data
- flush  in  1  clear all pending bits (pipeline squash)
- debug_reg  in  ADDR_WIDTH  debug read index
- debug_reg_out  out  WORD_SIZE  debug read data, never bypassed
- pending_count  out  ADDR_WIDTH+1  number of registers currently pending (registered)

## Operation
- Reset (rst low, asynchronous):
  - register 2 = SP_RESET, register 3 = GP_RESET, all other registers = 0
  - all pending bits = 0, pending_count = 0
  - outputs then follow from that state
- Register 0:
  - reads 0 on every port
  - writes to it are discarded
  - issue to it is ignored (never pending)
- Write: wb_en=1 and wb_rd!=0 stores wb_data into wb_rd at the clock edge.
- Read: rvN = storage[rsN], combinational.
  - With BYPASS=1, wb_en=1 and wb_rd==rsN!=0, rvN = wb_data instead.
- busyN = pending[rsN], except it is forced 0 when:
  - BYPASS=1, wb_en=1 and wb_rd==rsN (the value is being forwarded this cycle), or
  - rsN=0.
- Scoreboard update per edge, in priority order:
  1. flush=1: all pending cleared. A same-cycle write-back still writes data. Same-cycle issue is discarded.
  2. issue_en=1, issue_rd!=0: pending[issue_rd] set. This wins over a same-cycle wb to the same rd; data is still written.
  3. wb_en=1, wb_rd!=0, wb_rd not being issued this cycle: pending[wb_rd] cleared.
- Issue to an already-pending register is legal; the bit stays set. The core guarantees in-order write-back, so the first write-back clears it.
- Write-back to a non-pending register is legal (writes data, no scoreboard change).
- pending_count is always the population count of the pending bits after the edge.
  - It is maintained incrementally: +1, -1 or 0 per edge; set to 0 on flush.
  - It must never wrap.

## Timing
- Read and bypass latency: 0 cycles, combinational from rsN/wb_*.
- A written value is visible on non-bypassed paths (debug, BYPASS=0) from the cycle after the write edge.
- Pending set by issue is visible on busyN the cycle after the issue edge.
- Pending cleared by wb is visible after the edge. With BYPASS=1, busyN already drops in the wb cycle itself.
- With BYPASS=0 the hazard window includes the wb cycle; decode must stall one extra cycle.
- pending_count is updated on the same edge as the pending bits.
- Reset mid-operation: all state returns immediately to reset values. Outstanding pending bits are lost; no write completes during reset.

## Test plan
- Reset: release rst, read all 32 registers via debug_reg → r2=32'h7ffc, r3=32'h1000, others 0, pending_count=0, busy1=busy2=0.
- Write/read: wb r5=32'hdeadbeef; next cycle rs1=5 → rv1=32'hdeadbeef. Write 32'h1 to r0 → rv2(rs2=0)=0.
- Bypass:
  - BYPASS=1: wb_en with r7=32'h55, rs1=7 in the same cycle → rv1=32'h55 and busy1=0, while debug_reg_out(7) still shows the old value.
  - BYPASS=0: same stimulus → rv1 shows the old value.
- Scoreboard:
  - Issue r9 → next cycle busy1(rs1=9)=1, pending_count=1.
  - Issue r9 again → count stays 1.
  - wb r9=32'h10 → count 0, busy1=0, rv1=32'h10.
- Simultaneous events:
  - Issue r4 and wb r4 (pending) in the same cycle → r4 written, still pending, count unchanged.
  - Issue r1, r2, r6, then flush with wb r1 → count 0, r1 updated.
- Async reset mid-operation: three pending registers and r5 written; assert rst between clock edges → count 0 and r5=0 immediately, without a clock edge.
